uart_tx_stim: RTL and testbench

- Synthesizable 8-bit UART transmitter with a byte FIFO, sending LSB-first serial frames.
- Serves as the host-to-SoC half of the console link in simulation. Its tx output drives the SoC's io_uart_rx, and the tty model monitors io_uart_tx.
- Bench or DPI code pushes characters through a valid/ready port. The block serializes them at a fixed clocks-per-bit rate.
- Also usable on-chip as a generic UART TX.

---
 rtl/uart_tx_stim.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx_stim.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stim.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_stim
// Purpose  : 8-bit UART transmitter fed through a byte FIFO. Bytes pushed on a
//            valid/ready port are serialized LSB-first as start / 8 data /
//            [parity] / stop frames at a fixed CLKS_PER_BIT rate. Frames are
//            sent back to back with no idle gap while the FIFO holds data.
// Ports    : clock      - sole clock, rising edge
//            reset      - asynchronous, active-high reset
//            in_valid   - byte offered on in_data
//            in_ready   - FIFO has room (registered count only)
//            in_data    - byte to send
//            tx         - serial line, idles high (registered)
//            busy       - FIFO non-empty or frame in progress
//            fifo_count - current FIFO occupancy
//            tx_done    - one-cycle pulse on the final stop-bit cycle
// Options  : UART_TX_PARITY_EN - insert a parity bit (PARITY_ODD selects
//            odd/even) between the data bits and the stop bit(s).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_stim #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done
);

  localparam int              AW          = $clog2(FIFO_DEPTH);
  localparam int              CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]     DEPTH       = (AW + 1)'(FIFO_DEPTH);
  // Index of the last stop bit: 0 for one stop bit, 1 for two.
  localparam logic            STOP_LAST   = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            stop_q, stop_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic            push, pop, start_frame, last_stop;
  logic [7:0]      head;

  assign head       = mem_q[rd_ptr_q];
  assign in_ready   = (count_q != DEPTH);
  assign push       = in_valid && in_ready;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign last_stop  = (state_q == S_STOP) && (baud_q == '0) && (stop_q == STOP_LAST);
  assign tx_done    = last_stop;

  // Next-state logic. A new frame is launched from IDLE or straight out of
  // the final stop cycle, so the pop/load is shared via start_frame.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    stop_d      = stop_q;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) start_frame = 1'b1;
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d   = S_DATA;
          baud_d    = BAUD_RELOAD;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == '0) begin
          state_d = S_STOP;
          baud_d  = BAUD_RELOAD;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_q == '0) begin
          if (stop_q == STOP_LAST) begin
            if (count_q != '0) start_frame = 1'b1;
            else               state_d     = S_IDLE;
          end else begin
            stop_d = 1'b1;
            baud_d = BAUD_RELOAD;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (start_frame) begin
      state_d = S_START;
      baud_d  = BAUD_RELOAD;
      shift_d = head;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = (^head) ^ PARITY_ODD[0];
`endif
    end
  end

  assign pop = start_frame;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      stop_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      stop_q    <= stop_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stim.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_stim
// Purpose  : Self-checking bench for uart_tx_stim (CLKS_PER_BIT=4,
//            FIFO_DEPTH=8, one stop bit). Expected line levels come from a
//            frame-bit model; a line monitor decodes frames independently.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stim;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'd0;
  logic       in_ready, tx, busy, tx_done;
  logic [3:0] fifo_count;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [8:0] rx_q[$];
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  uart_tx_stim #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .STOP_BITS    (1),
    .PARITY_ODD   (0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .tx_done    (tx_done)
  );

  // Line monitor: finds the falling start edge, samples each bit mid-period
  // and records {stop_bit, byte}. Reset abandons a frame in progress.
  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = 8'd0;

  always @(negedge clock) begin
    if (reset) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if ((mon_cnt % CPB) == (CPB / 2)) begin
        if ((mon_cnt / CPB) >= 1 && (mon_cnt / CPB) <= 8)
          mon_byte[(mon_cnt / CPB) - 1] <= tx;
        if ((mon_cnt / CPB) == NBITS - 1) begin
          rx_q.push_back({tx, mon_byte});
          mon_active <= 1'b0;
        end
      end
    end
  end

  // Frame model: start, data LSB-first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NBITS == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Push one or two bytes on consecutive edges into an idle, empty DUT and
  // check every cycle of the resulting frame(s). Entered at a negedge.
  task automatic run_frames(input logic [7:0] b0, input logic [7:0] b1, input int n);
    logic [7:0] cur;
    in_valid = 1'b1;
    in_data  = b0;
    @(negedge clock);
    chk("push_cnt",  fifo_count, 1);
    chk("push_busy", busy, 1);
    chk("push_tx",   tx, 1);
    if (n == 2) in_data = b1;
    else        in_valid = 1'b0;
    for (int j = 1; j <= n * FRAME; j++) begin
      @(negedge clock);
      in_valid = 1'b0;
      cur = ((j - 1) / FRAME == 0) ? b0 : b1;
      chk("frame_tx",   tx, exp_bit(cur, ((j - 1) % FRAME) / CPB));
      chk("frame_done", tx_done, ((j % FRAME) == 0));
      chk("frame_cnt",  fifo_count, (n == 2 && j <= FRAME) ? 1 : 0);
      chk("frame_busy", busy, 1);
    end
    @(negedge clock);
    chk("end_busy", busy, 0);
    chk("end_tx",   tx, 1);
    chk("end_done", tx_done, 0);
    exp_q.push_back(b0);
    if (n == 2) exp_q.push_back(b1);
  endtask

  task automatic check_rx();
    chk("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk("rx_byte", rx_q[i], {1'b1, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] fb[10];
    int         cnt;
    int         idx;
    logic       rdy_e, push_e, pop_e;

    // Reset with in_valid asserted: nothing may be counted.
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_tx",    tx, 1);
      chk("rst_ready", in_ready, 1);
      chk("rst_busy",  busy, 0);
      chk("rst_cnt",   fifo_count, 0);
      chk("rst_done",  tx_done, 0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("post_rst_cnt",  fifo_count, 0);
    chk("post_rst_busy", busy, 0);

    // Single frames.
    run_frames(8'h55, 8'h00, 1);
    for (int i = 0; i < 3; i++) run_frames(8'($urandom), 8'h00, 1);
`ifdef UART_TX_PARITY_EN
    run_frames(8'h07, 8'h00, 1);
`endif
    check_rx();

    // Back-to-back pairs.
    run_frames(8'hA5, 8'h3C, 2);
    for (int i = 0; i < 2; i++) run_frames(8'($urandom), 8'($urandom), 2);
    check_rx();

    // Overfill: 10 bytes offered continuously; the model tracks occupancy
    // from pushes accepted and one pop per frame period.
    for (int i = 0; i < 10; i++) fb[i] = 8'($urandom);
    cnt = 0;
    idx = 0;
    for (int t = 0; t <= 10 * FRAME + 20; t++) begin
      if (idx < 10) begin
        in_valid = 1'b1;
        in_data  = fb[idx];
      end else begin
        in_valid = 1'b0;
      end
      rdy_e = (cnt != DEPTH);
      chk("full_ready", in_ready, rdy_e);
      push_e = in_valid && rdy_e;
      pop_e  = (t >= 1) && (((t - 1) % FRAME) == 0) && (cnt > 0);
      cnt    = cnt + (push_e ? 1 : 0) - (pop_e ? 1 : 0);
      if (push_e) idx++;
      @(negedge clock);
      chk("full_cnt",  fifo_count, cnt);
      chk("full_done", tx_done, (t >= FRAME) && (t <= 10 * FRAME) && ((t % FRAME) == 0));
    end
    in_valid = 1'b0;
    chk("full_all_pushed", idx, 10);
    for (int i = 0; i < 10; i++) exp_q.push_back(fb[i]);
    check_rx();

    // Reset during data bit 3 of 0xFF with a second byte still queued.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clock);
    in_data  = 8'h3C;
    @(negedge clock);
    in_valid = 1'b0;
    chk("mid_cnt", fifo_count, 1);
    repeat (17) @(negedge clock);
    chk("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx",    tx, 1);
    chk("mid_rst_cnt",   fifo_count, 0);
    chk("mid_rst_busy",  busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_done",  tx_done, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset during a start bit: tx must return high immediately.
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk("start_tx_low", tx, 0);
    #2 reset = 1'b1;
    #1;
    chk("start_rst_tx",  tx, 1);
    chk("start_rst_cnt", fifo_count, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("after_rst_idle", busy, 0);

    run_frames(8'h81, 8'h00, 1);
    check_rx();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
